// File: rtl/posit_add_scheduler.sv
// Schedules one posit addition at a time through an external fault checker:
// truncated result when the checker reports no fault, full-width retry otherwise.
module posit_add_scheduler #(
    parameter int FULL_NBITS  = 32,
    parameter int TRUNC_NBITS = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FULL_NBITS-1:0] in_a,
    input  logic [FULL_NBITS-1:0] in_b,
    input  logic                  force_full,
    output logic [FULL_NBITS-1:0] chk_a,
    output logic [FULL_NBITS-1:0] chk_b,
    input  logic                  chk_mode,
    input  logic                  chk_fault,
    input  logic [FULL_NBITS-1:0] chk_used_sum,
    input  logic [FULL_NBITS-1:0] chk_true_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FULL_NBITS-1:0] out_sum,
    output logic                  out_trunc,
    output logic                  out_retried,
    output logic [CNT_W-1:0]      fault_cnt,
    output logic [CNT_W-1:0]      trunc_cnt
);
    localparam int PAD_W = FULL_NBITS - TRUNC_NBITS;

    typedef enum logic [1:0] {IDLE, EVAL, RETRY, HOLD} state_e;

    state_e                state_q, state_d;
    logic [FULL_NBITS-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic                  ff_q, ff_d;
    logic [FULL_NBITS-1:0] sum_q, sum_d;
    logic                  trunc_q, trunc_d, retried_q, retried_d;
    logic [CNT_W-1:0]      fault_cnt_q, fault_cnt_d, trunc_cnt_q, trunc_cnt_d;

    // The truncated adder only produces the low TRUNC_NBITS bits.
    logic unused_used_hi;
    assign unused_used_hi = ^chk_used_sum[FULL_NBITS-1:TRUNC_NBITS];

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        ff_d        = ff_q;
        sum_d       = sum_q;
        trunc_d     = trunc_q;
        retried_d   = retried_q;
        fault_cnt_d = fault_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
                    ff_d    = force_full;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (ff_q || !chk_mode) begin
                    sum_d     = chk_true_sum;
                    trunc_d   = 1'b0;
                    retried_d = 1'b0;
                    state_d   = HOLD;
                end else if (!chk_fault) begin
                    sum_d     = {chk_used_sum[TRUNC_NBITS-1:0], {PAD_W{1'b0}}};
                    trunc_d   = 1'b1;
                    retried_d = 1'b0;
                    if (!(&trunc_cnt_q)) trunc_cnt_d = trunc_cnt_q + 1'b1;
                    state_d   = HOLD;
                end else begin
                    if (!(&fault_cnt_q)) fault_cnt_d = fault_cnt_q + 1'b1;
                    state_d = RETRY;
                end
            end
            RETRY: begin
                sum_d     = chk_true_sum;
                trunc_d   = 1'b0;
                retried_d = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            ff_q        <= 1'b0;
            sum_q       <= '0;
            trunc_q     <= 1'b0;
            retried_q   <= 1'b0;
            fault_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            ff_q        <= ff_d;
            sum_q       <= sum_d;
            trunc_q     <= trunc_d;
            retried_q   <= retried_d;
            fault_cnt_q <= fault_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == HOLD);
    assign chk_a       = op_a_q;
    assign chk_b       = op_b_q;
    assign out_sum     = sum_q;
    assign out_trunc   = trunc_q;
    assign out_retried = retried_q;
    assign fault_cnt   = fault_cnt_q;
    assign trunc_cnt   = trunc_cnt_q;
endmodule
